inv_mix_columns_seq: RTL and testbench

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

---
 rtl/inv_mix_columns_seq.sv | 103 ++++++++++
 tb/tb_inv_mix_columns_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns over a 128-bit state, one column per cycle through a shared
// column datapath, with a valid/ready handshake on both sides.
module inv_mix_columns_seq #(
    parameter int BYTE   = 8,
    parameter int DWORD  = 32,
    parameter int LENGTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] inpt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] oupt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [LENGTH-1:0] in_reg;
    logic [DWORD-1:0]  col_out;

    function automatic logic [BYTE-1:0] xt(input logic [BYTE-1:0] b);
        return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? BYTE'(8'h1b) : '0);
    endfunction

    // Coefficients 09/0b/0d/0e built from the x2/x4/x8 xtime chain of each byte.
    function automatic logic [DWORD-1:0] col_inv(input logic [DWORD-1:0] w);
        logic [BYTE-1:0] s  [4];
        logic [BYTE-1:0] m9 [4];
        logic [BYTE-1:0] mb [4];
        logic [BYTE-1:0] md [4];
        logic [BYTE-1:0] me [4];
        logic [BYTE-1:0] x2, x4, x8;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]  = w[DWORD-1-BYTE*i -: BYTE];
            x2    = xt(s[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        col_out = col_inv(in_reg[cnt*DWORD +: DWORD]);
    end

    // in_ready is combinational in DONE so a new block can enter as the result leaves.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign busy     = (state == COMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            oupt      <= '0;
            in_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg <= inpt;
                        cnt    <= '0;
                        state  <= COMP;
                    end
                end
                COMP: begin
                    oupt[cnt*DWORD +: DWORD] <= col_out;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            in_reg <= inpt;
                            cnt    <= '0;
                            state  <= COMP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Randomized self-checking bench for inv_mix_columns_seq against a GF(2^8)
// reference model of MixColumns / InvMixColumns.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] inpt;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] oupt;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_q[$];
    bit           hold;
    logic [127:0] hold_data;
    bit           rand_ready = 0;

    inv_mix_columns_seq #(.BYTE(8), .DWORD(32), .LENGTH(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inpt(inpt), .out_valid(out_valid), .out_ready(out_ready),
        .oupt(oupt), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Row r uses the first-row coefficients rotated right by r bytes.
    function automatic logic [127:0] col_mix(input logic [127:0] x, input logic [31:0] coefs);
        logic [127:0] y = '0;
        logic [7:0]   cf[4];
        logic [7:0]   s[4];
        logic [7:0]   acc;
        for (int k = 0; k < 4; k++) cf[k] = coefs[31-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) s[r] = x[32*c + 31 - 8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(cf[(k - r + 4) % 4], s[k]);
                y[32*c + 31 - 8*r -: 8] = acc;
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] x);
        return col_mix(x, 32'h02030101);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        return col_mix(x, 32'h0e0b0d09);
    endfunction

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) check("hold_stable", {out_valid, oupt}, {1'b1, hold_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got %h expected no output", oupt);
                end else begin
                    check("result", {1'b0, oupt}, {1'b0, exp_q.pop_front()});
                end
            end
            hold      = out_valid && !out_ready;
            hold_data = oupt;
            if (in_valid && in_ready) exp_q.push_back(inv_mix(inpt));
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom % 3) != 0;
        end
    end

    task automatic wait_accept(output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (in_ready) ok = 1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        if (!ok) check("out_timeout", 0, 1);
    endtask

    task automatic run_latency(input logic [127:0] x, input logic [127:0] y);
        int n;
        inpt     = x;
        in_valid = 1;
        wait_accept(n);
        in_valid = 0;
        inpt     = {4{$urandom}};
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("lat_valid", out_valid, (i == 4));
            check("lat_busy", busy, (i < 4));
        end
        check("lat_value", oupt, y);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        check("after_done", {in_ready, out_valid}, 2'b10);
        check("retained", oupt, y);
    endtask

    initial begin
        int  n;
        bit  stale;
        logic [127:0] x;

        rst = 1; in_valid = 0; out_ready = 0; inpt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {out_valid, busy, oupt}, '0);
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);

        check("model_col0", inv_mix({96'h0, 32'h8e4da1bc}), {96'h0, 32'hdb135345});
        check("model_full", inv_mix(128'h9fdc589d_4d7ebdf8_c6c6c6c6_01010101),
              128'hf20a225c_2d26314c_c6c6c6c6_01010101);
        check("model_fwd", mix(128'hf20a225c_2d26314c_c6c6c6c6_01010101),
              128'h9fdc589d_4d7ebdf8_c6c6c6c6_01010101);

        @(posedge clk);
        #1;
        run_latency({96'h0, 32'h8e4da1bc}, {96'h0, 32'hdb135345});
        run_latency(128'h9fdc589d_4d7ebdf8_c6c6c6c6_01010101,
                    128'hf20a225c_2d26314c_c6c6c6c6_01010101);

        // Backpressure: result held while new requests are refused.
        inpt = {4{$urandom}}; in_valid = 1;
        wait_accept(n);
        in_valid = 0;
        wait_out();
        @(posedge clk);
        #1;
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            inpt = {4{$urandom}};
            @(posedge clk);
            #1;
            check("bp_no_accept", {in_ready, busy, out_valid}, 3'b001);
        end
        inpt = {4{$urandom}};
        out_ready = 1;
        #1;
        check("bp_ready_comb", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 0; out_ready = 0;
        check("bp_direct_comp", {busy, out_valid}, 2'b10);
        wait_out();
        @(posedge clk);
        #1;
        out_ready = 1;
        @(posedge clk);
        #1;

        // Back-to-back blocks, one every 5 cycles.
        in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            inpt = {4{$urandom}};
            wait_accept(n);
            if (k > 0) check("b2b_period", n, 5);
        end
        in_valid = 0;
        repeat (12) @(negedge clk);
        check("b2b_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        out_ready = 0;

        // Reset with counter at 2 discards the block.
        inpt = {4{$urandom}}; in_valid = 1;
        wait_accept(n);
        in_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk);
        #1;
        check("midcomp_reset", {out_valid, busy, in_ready, oupt}, {3'b001, 128'h0});
        exp_q.delete();
        rst = 0;
        out_ready = 1;
        stale = 0;
        repeat (8) begin @(negedge clk); if (out_valid || oupt != '0) stale = 1; end
        check("no_stale", stale, 0);
        out_ready = 0;

        // Random round trip with random stalls and input gaps.
        rand_ready = 1;
        for (int k = 0; k < 1000; k++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            inpt = mix(x);
            in_valid = 1;
            wait_accept(n);
            if (($urandom % 3) == 0) begin
                in_valid = 0;
                inpt = {4{$urandom}};
                @(posedge clk);
                #1;
            end
        end
        in_valid = 0;
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1;
        repeat (12) @(negedge clk);
        check("rt_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
